sd_crc_lanes: RTL



---
 rtl/sd_crc_lanes.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sd_crc_lanes.sv
// sd_crc_lanes: multi-lane CRC engine for the SD host datapath.
// One independent CRC shift register per lane, plus a sequenced MSB-first
// shift-out of the CRCs (SHIFT) and a receive-side residue check (CHECK).
// Optional: define SD_CRC_BITCOUNT_EN to add bit_count_o, a saturating count
// of data beats absorbed in IDLE since the last clear/reset.

// Single CRC lane: holds one shift register and exposes its next value so
// the controller can judge the residue on the same edge it is produced.
module sd_crc_lane #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = 16'h1021
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             zero_i,   // force register to zero
   input  logic             shift_i,  // plain left shift, no feedback
   input  logic             upd_i,    // absorb data_i through the polynomial
   input  logic             data_i,
   output logic [WIDTH-1:0] sr_o,
   output logic [WIDTH-1:0] sr_d_o
);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic             fb;

   // Next-state: zero beats shift beats update; otherwise hold.
   always_comb begin
      fb   = sr_q[WIDTH-1] ^ data_i;
      sr_d = sr_q;
      if (zero_i)
         sr_d = '0;
      else if (shift_i)
         sr_d = {sr_q[WIDTH-2:0], 1'b0};
      else if (upd_i)
         sr_d = {sr_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
   end

   // CRC register.
   always_ff @(posedge clk_i) begin
      if (reset_i) sr_q <= '0;
      else         sr_q <= sr_d;
   end

   assign sr_o   = sr_q;
   assign sr_d_o = sr_d;

endmodule

module sd_crc_lanes #(
   parameter int          WIDTH = 16,
   parameter logic [31:0] POLY  = 32'h1021,
   parameter int          LANES = 4
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   clear_i,
   input  logic                   data_valid_i,
   input  logic [LANES-1:0]       data_i,
   input  logic                   append_i,
   input  logic                   check_i,
   output logic [LANES*WIDTH-1:0] crc_o,
   output logic [LANES-1:0]       crc_bit_o,
   output logic                   shift_valid_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [LANES-1:0]       crc_ok_o
`ifdef SD_CRC_BITCOUNT_EN
   ,
   output logic [15:0]            bit_count_o
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] P = POLY[WIDTH-1:0];

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

   state_t                         state_q;
   logic [CW-1:0]                  cnt_q;
   logic                           shift_valid_q, busy_q, done_q;
   logic [LANES-1:0]               crc_ok_q;
   logic [LANES-1:0][WIDTH-1:0]    sr, sr_d;
   logic [LANES-1:0]               zero_res;
   logic                           cnt_last, idle_absorb, lane_upd, lane_shift, lane_zero;

   // Lane control decode. In IDLE, append and check both win over data, so a
   // beat arriving with either pulse is not absorbed.
   always_comb begin
      cnt_last    = (cnt_q == CW'(WIDTH-1));
      idle_absorb = (state_q == S_IDLE) && data_valid_i && !append_i && !check_i;
      lane_upd    = idle_absorb || ((state_q == S_CHECK) && data_valid_i);
      lane_shift  = (state_q == S_SHIFT);
      lane_zero   = clear_i || ((state_q == S_SHIFT) && cnt_last);
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sd_crc_lane #(.WIDTH(WIDTH), .POLY(P)) u_lane (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .zero_i  (lane_zero),
         .shift_i (lane_shift),
         .upd_i   (lane_upd),
         .data_i  (data_i[i]),
         .sr_o    (sr[i]),
         .sr_d_o  (sr_d[i])
      );
      assign zero_res[i]  = (sr_d[i] == '0);
      assign crc_bit_o[i] = shift_valid_q & sr[i][WIDTH-1];
   end

   // Sequencer: counts WIDTH shift cycles or WIDTH received check beats.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         shift_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         crc_ok_q      <= '0;
      end else if (clear_i) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         shift_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (append_i) begin
                  state_q       <= S_SHIFT;
                  cnt_q         <= '0;
                  shift_valid_q <= 1'b1;
                  busy_q        <= 1'b1;
               end else if (check_i) begin
                  state_q  <= S_CHECK;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  crc_ok_q <= '0;
               end
            end
            S_SHIFT: begin
               if (cnt_last) begin
                  state_q       <= S_IDLE;
                  shift_valid_q <= 1'b0;
                  busy_q        <= 1'b0;
                  done_q        <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_CHECK: begin
               if (data_valid_i) begin
                  if (cnt_last) begin
                     state_q  <= S_IDLE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     crc_ok_q <= zero_res;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef SD_CRC_BITCOUNT_EN
   logic [15:0] bit_cnt_q;

   // Saturating count of beats absorbed while accumulating.
   always_ff @(posedge clk_i) begin
      if (reset_i || clear_i)
         bit_cnt_q <= '0;
      else if (idle_absorb && (bit_cnt_q != 16'hFFFF))
         bit_cnt_q <= bit_cnt_q + 16'd1;
   end

   assign bit_count_o = bit_cnt_q;
`endif

   assign crc_o         = sr;
   assign shift_valid_o = shift_valid_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign crc_ok_o      = crc_ok_q;

endmodule
